// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the MEM-stage access controller:
// FSM state encoding and the default access timeout.
package mem_stage_ctrl_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_sat_counter.sv
// Saturating event counter with asynchronous active-high reset.
// Counts one per cycle with inc=1 and holds once it reaches all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: sequences data-memory accesses, stalls the front of
// the pipeline while an access is outstanding, and redirects the PC on taken branches.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Memread,
  input  logic             MemWrite,
  input  logic             Branch,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             stall,
  output logic             memwb_bubble,
  output logic             flush,
  output logic             pc_sel,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [7:0]       timeout_cnt,
  output state_e           dbg_state
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_d, state_q;
  logic [WAIT_W-1:0] wait_d, wait_q;
  logic              timeout_err_d, timeout_err_q;
  logic              mem_op, branch_taken, req_c, timeout_hit;

  // Handshake: mem_req is held high from the request cycle until the cycle
  // mem_ack is seen (or the wait budget runs out); the access completes on the
  // rising edge where mem_req=1 and mem_ack=1. mem_ack with mem_req=0 is ignored.
  always_comb begin
    mem_op       = Memread | MemWrite;
    branch_taken = Branch & zero;
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_hit  = 1'b0;
    req_c        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_c = mem_op;
        if (mem_op) begin
          state_d = mem_ack ? ST_DONE : ST_BUSY;
          wait_d  = '0;
        end
      end
      ST_BUSY: begin
        req_c = 1'b1;
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = ST_DONE;
          timeout_hit = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    timeout_err_d = timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Gating with reset keeps every output low while reset is held, even if
  // a mem_op is presented to the forced IDLE state.
  assign mem_req      = req_c & ~reset;
  assign mem_we       = mem_req & MemWrite;
  assign stall        = mem_req;
  assign memwb_bubble = stall;
  assign flush        = branch_taken & ~stall & ~reset;
  assign pc_sel       = flush;
  assign timeout_err  = timeout_err_q;
  assign dbg_state    = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (reset),
    .inc (stall),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(8)) u_timeout_cnt (
    .clk (clk),
    .rst (reset),
    .inc (timeout_hit),
    .cnt (timeout_cnt)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a cycle-by-cycle vector table followed
// by hand-written sequences for wait states, timeout, reset abort and saturation.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;
  logic Memread, MemWrite, Branch, zero, mem_ack;
  logic mem_req, mem_we, stall, memwb_bubble, flush, pc_sel, timeout_err;
  logic [CW-1:0] stall_cnt;
  logic [7:0] timeout_cnt;
  state_e dbg_state;

  int n_checks = 0;
  int n_err = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(15), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .Memread      (Memread),
    .MemWrite     (MemWrite),
    .Branch       (Branch),
    .zero         (zero),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .stall        (stall),
    .memwb_bubble (memwb_bubble),
    .flush        (flush),
    .pc_sel       (pc_sel),
    .timeout_err  (timeout_err),
    .stall_cnt    (stall_cnt),
    .timeout_cnt  (timeout_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  logic [6:0] obs;
  assign obs = {mem_req, mem_we, stall, memwb_bubble, flush, pc_sel, timeout_err};

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] in;     // {Memread, MemWrite, Branch, zero, mem_ack}
    logic [6:0] exp_o;  // {req, we, stall, bubble, flush, pc_sel, timeout_err}
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[16];
  logic [8:0] exp_q[$];

  function automatic vec_t mk(logic [4:0] in, logic [6:0] o, logic [1:0] st);
    vec_t v;
    v.in = in;
    v.exp_o = o;
    v.exp_st = st;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(logic [4:0] v);
    {Memread, MemWrite, Branch, zero, mem_ack} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(5'b10000);
    #1;
    chk("reset_outputs", 32'(obs), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("reset_counters", {19'd0, stall_cnt, timeout_cnt}, 32'd0);
    step();
    reset = 1'b0;
    set_in(5'b00000);
  endtask

  // One load that never gets an ack; returns stall/busy cycle counts.
  task automatic run_timeout(output int n_stall, output int n_busy);
    int n;
    n = 0;
    n_stall = 0;
    n_busy = 0;
    set_in(5'b10000);
    while (dbg_state != ST_DONE && n < 40) begin
      #1;
      if (stall) n_stall++;
      if (dbg_state == ST_BUSY) n_busy++;
      step();
      n++;
    end
    chk("timeout_bound", 32'(n < 40), 32'd1);
    set_in(5'b00000);
    #1;
    chk("timeout_err_in_done", 32'(timeout_err), 32'd1);
    step();
  endtask

  // ---------------- main test ----------------
  initial begin
    int ns, nb, c_rw, c_st, c_bub;
    logic [1:0] st4;
    logic [8:0] e;

    //                 rd wr br z ack     req we st bub fl pc te
    vecs[0]  = mk(5'b00000, 7'b0000000, ST_IDLE);
    vecs[1]  = mk(5'b00110, 7'b0000110, ST_IDLE);
    vecs[2]  = mk(5'b00100, 7'b0000000, ST_IDLE);
    vecs[3]  = mk(5'b00001, 7'b0000000, ST_IDLE);
    vecs[4]  = mk(5'b10001, 7'b1011000, ST_IDLE);
    vecs[5]  = mk(5'b00001, 7'b0000000, ST_DONE);
    vecs[6]  = mk(5'b01000, 7'b1111000, ST_IDLE);
    vecs[7]  = mk(5'b01000, 7'b1111000, ST_BUSY);
    vecs[8]  = mk(5'b01001, 7'b1111000, ST_BUSY);
    vecs[9]  = mk(5'b00000, 7'b0000000, ST_DONE);
    vecs[10] = mk(5'b11111, 7'b1111000, ST_IDLE);
    vecs[11] = mk(5'b11110, 7'b0000110, ST_DONE);
    vecs[12] = mk(5'b10000, 7'b1011000, ST_IDLE);
    vecs[13] = mk(5'b10110, 7'b1011000, ST_BUSY);
    vecs[14] = mk(5'b10001, 7'b1011000, ST_BUSY);
    vecs[15] = mk(5'b00000, 7'b0000000, ST_DONE);

    do_reset();

    foreach (vecs[i]) exp_q.push_back({vecs[i].exp_st, vecs[i].exp_o});
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].in);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d", i), {23'd0, dbg_state, obs}, {23'd0, e});
      step();
    end
    chk("table_state_end", 32'(dbg_state), 32'(ST_IDLE));
    chk("table_stall_cnt", 32'(stall_cnt), 32'd8);
    chk("table_timeout_cnt", 32'(timeout_cnt), 32'd0);

    // Zero-wait load: one stall cycle.
    do_reset();
    set_in(5'b10001);
    #1;
    chk("zw_stall", 32'(stall), 32'd1);
    step();
    set_in(5'b00000);
    #1;
    chk("zw_done", 32'(dbg_state), 32'(ST_DONE));
    chk("zw_done_stall", 32'(stall), 32'd0);
    chk("zw_stall_cnt", 32'(stall_cnt), 32'd1);

    // Store acked in the 3rd BUSY cycle: four request/stall cycles.
    do_reset();
    c_rw = 0; c_st = 0; c_bub = 0; st4 = 2'b11;
    for (int k = 0; k < 6; k++) begin
      set_in({1'b0, (k < 4), 2'b00, (k == 3)});
      #1;
      if (mem_req && mem_we) c_rw++;
      if (stall) c_st++;
      if (memwb_bubble != stall) c_bub++;
      if (k == 4) st4 = dbg_state;
      step();
    end
    chk("st3_req_we_cycles", 32'(c_rw), 32'd4);
    chk("st3_stall_cycles", 32'(c_st), 32'd4);
    chk("st3_bubble_diff", 32'(c_bub), 32'd0);
    chk("st3_done", 32'(st4), 32'(ST_DONE));
    chk("st3_stall_cnt", 32'(stall_cnt), 32'd4);

    // Load that is never acked: 15 BUSY cycles then abort.
    do_reset();
    run_timeout(ns, nb);
    chk("to_stall_cycles", 32'(ns), 32'd16);
    chk("to_busy_cycles", 32'(nb), 32'd15);
    chk("to_timeout_cnt", 32'(timeout_cnt), 32'd1);
    chk("to_stall_cnt", 32'(stall_cnt), 32'd16);
    #1;
    chk("to_idle_after", 32'(dbg_state), 32'(ST_IDLE));
    chk("to_err_pulse_end", 32'(timeout_err), 32'd0);

    // Reset during the 2nd BUSY cycle abandons the access.
    do_reset();
    set_in(5'b01000);
    step();
    step();
    chk("rb_busy", 32'(dbg_state), 32'(ST_BUSY));
    chk("rb_cnt_pre", 32'(stall_cnt), 32'd2);
    reset = 1'b1;
    #1;
    chk("rb_req_drop", 32'(mem_req), 32'd0);
    chk("rb_outputs", 32'(obs), 32'd0);
    chk("rb_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rb_stall_cnt", 32'(stall_cnt), 32'd0);
    step();
    reset = 1'b0;
    set_in(5'b00000);
    c_st = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (timeout_err || dbg_state != ST_IDLE) c_st++;
      step();
    end
    chk("rb_quiet_after", 32'(c_st), 32'd0);
    chk("rb_timeout_cnt", 32'(timeout_cnt), 32'd0);

    // Saturation of both counters, plus spurious acks around a zero-wait load.
    do_reset();
    run_timeout(ns, nb);
    run_timeout(ns, nb);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd31);
    set_in(5'b00001);
    step();
    chk("sat_spur_idle", 32'(dbg_state), 32'(ST_IDLE));
    set_in(5'b10001);
    step();
    set_in(5'b00001);
    #1;
    chk("sat_spur_done_req", 32'(mem_req), 32'd0);
    step();
    chk("sat_spur_back_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("sat_stall_hold", 32'(stall_cnt), 32'd31);
    set_in(5'b00000);
    for (int k = 2; k < 255; k++) run_timeout(ns, nb);
    chk("sat_to_255", 32'(timeout_cnt), 32'd255);
    run_timeout(ns, nb);
    chk("sat_to_hold", 32'(timeout_cnt), 32'd255);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
